// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring
// divide sharing one 64-bit working register, with a one-cycle sign-fix pass before DONE.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_out,
    output logic        write_reg
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    logic [2:0]  op;
    logic [4:0]  rd_lat;
    logic [31:0] opnd;      // multiplicand for MUL*, divisor for DIV*/REM*
    logic [63:0] prod;      // {acc, multiplier} or {remainder, dividend/quotient}
    logic [5:0]  cnt;
    logic        neg;
    logic        special;

    // Operand decode at acceptance
    logic        a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
    logic [31:0] a_abs, b_abs;

    always_comb begin
        a_sgn    = ~(funct3[0] & (funct3[1] | funct3[2]));
        b_sgn    = funct3[2] ? ~funct3[0] : ~funct3[1];
        a_neg    = a_sgn & rs1_data[31];
        b_neg    = b_sgn & rs2_data[31];
        a_abs    = a_neg ? (32'd0 - rs1_data) : rs1_data;
        b_abs    = b_neg ? (32'd0 - rs2_data) : rs2_data;
        div_zero = funct3[2] && (rs2_data == 32'd0);
        div_ovf  = funct3[2] && !funct3[0] && (rs1_data == 32'h8000_0000)
                   && (rs2_data == 32'hFFFF_FFFF);
    end

    // One iteration of each algorithm
    logic [32:0] mul_sum, rem_t, diff;
    logic [63:0] mul_next, div_next;
    logic        qbit;

    always_comb begin
        mul_sum  = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, opnd} : 33'd0);
        mul_next = {mul_sum, prod[31:1]};
        rem_t    = prod[63:31];
        diff     = rem_t - {1'b0, opnd};
        qbit     = ~diff[32];
        div_next = {(qbit ? diff[31:0] : rem_t[31:0]), prod[30:0], qbit};
    end

    // Sign fix and result select
    logic [63:0] prod_neg;
    logic [31:0] fin;

    always_comb begin
        prod_neg = 64'd0 - prod;
        fin      = 32'd0;
        case (op)
            3'b000:                 fin = neg ? prod_neg[31:0]  : prod[31:0];
            3'b001, 3'b010, 3'b011: fin = neg ? prod_neg[63:32] : prod[63:32];
            3'b100, 3'b101:         fin = neg ? (32'd0 - prod[31:0])  : prod[31:0];
            default:                fin = neg ? (32'd0 - prod[63:32]) : prod[63:32];
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            op        <= 3'd0;
            rd_lat    <= 5'd0;
            opnd      <= 32'd0;
            prod      <= 64'd0;
            cnt       <= 6'd0;
            neg       <= 1'b0;
            special   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            write_reg <= 1'b0;
            result    <= 32'd0;
            rd_out    <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    done      <= 1'b0;
                    write_reg <= 1'b0;
                    if (start) begin
                        op      <= funct3;
                        rd_lat  <= rd_in;
                        cnt     <= 6'd0;
                        busy    <= 1'b1;
                        special <= div_zero | div_ovf;
                        state   <= CALC;
                        // Special cases preload the final {rem, quo} and skip iteration
                        if (div_zero) begin
                            prod <= {rs1_data, 32'hFFFF_FFFF};
                            neg  <= 1'b0;
                        end else if (div_ovf) begin
                            prod <= {32'd0, 32'h8000_0000};
                            neg  <= 1'b0;
                        end else if (funct3[2]) begin
                            prod <= {32'd0, a_abs};
                            opnd <= b_abs;
                            neg  <= funct3[1] ? a_neg : (a_neg ^ b_neg);
                        end else begin
                            prod <= {32'd0, b_abs};
                            opnd <= a_abs;
                            neg  <= a_neg ^ b_neg;
                        end
                    end
                end
                CALC: begin
                    if (cnt == 6'd32) begin
                        result    <= fin;
                        rd_out    <= rd_lat;
                        done      <= 1'b1;
                        write_reg <= (rd_lat != 5'd0);
                        state     <= DONE;
                    end else if (special) begin
                        cnt <= 6'd32;
                    end else begin
                        prod <= op[2] ? div_next : mul_next;
                        cnt  <= cnt + 6'd1;
                    end
                end
                default: begin
                    done      <= 1'b0;
                    write_reg <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed checks for muldiv_unit: results, latency, write-back gating, start
// masking while busy, and asynchronous reset abort.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data, rs2_data;
    logic [4:0]  rd_in;
    logic        busy, done, write_reg;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int vectors = 0;
    int errors  = 0;

    muldiv_unit dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out),
        .write_reg(write_reg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the cycle following done.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat, input bit hold);
        int lat;
        lat = 0;
        start = 1'b1; funct3 = f3; rs1_data = a; rs2_data = b; rd_in = rd;
        @(posedge clk);
        #1;
        if (hold) begin
            funct3 = 3'b111; rs1_data = 32'hDEAD_BEEF; rs2_data = 32'h0000_0003; rd_in = 5'd31;
        end else begin
            start = 1'b0;
        end
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!done && lat < 60);
        start = 1'b0;
        chk({tag, " latency"},  lat,       exp_lat);
        chk({tag, " result"},   result,    exp);
        chk({tag, " rd_out"},   rd_out,    rd);
        chk({tag, " write_reg"}, write_reg, (rd != 5'd0));
        chk({tag, " busy_done"}, busy,     1'b1);
        @(negedge clk);
        chk({tag, " done_pulse"}, done,    1'b0);
        chk({tag, " busy_idle"}, busy,     1'b0);
        chk({tag, " result_hold"}, result, exp);
        chk({tag, " wr_idle"}, write_reg,  1'b0);
    endtask

    initial begin
        int seen;
        rst = 1'b0; start = 1'b0; funct3 = 3'd0; rs1_data = 32'd0; rs2_data = 32'd0; rd_in = 5'd0;
        @(negedge clk);
        chk("rst busy",   busy,      1'b0);
        chk("rst done",   done,      1'b0);
        chk("rst result", result,    32'd0);
        chk("rst rd_out", rd_out,    5'd0);
        chk("rst wr",     write_reg, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        run_op("mul_neg",     3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33, 1'b0);
        run_op("mulh_min",    3'b001, 32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000, 33, 1'b0);
        run_op("mulhu_min",   3'b011, 32'h8000_0000,  32'h8000_0000, 5'd2,  32'h4000_0000, 33, 1'b0);
        run_op("mulhsu",      3'b010, 32'hFFFF_FFFF,  32'h0000_0002, 5'd3,  32'hFFFF_FFFF, 33, 1'b0);
        run_op("mulhu_max",   3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE, 33, 1'b0);
        run_op("mul_m1m1",    3'b000, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'h0000_0001, 33, 1'b0);
        run_op("div_neg",     3'b100, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFD, 33, 1'b0);
        run_op("rem_neg",     3'b110, 32'hFFFF_FFF9,  32'd2,         5'd8,  32'hFFFF_FFFF, 33, 1'b0);
        run_op("divu",        3'b101, 32'd100,        32'd7,         5'd10, 32'd14,        33, 1'b0);
        run_op("remu",        3'b111, 32'd100,        32'd7,         5'd11, 32'd2,         33, 1'b0);
        run_op("divu_zero",   3'b101, 32'h0000_1234,  32'd0,         5'd12, 32'hFFFF_FFFF, 2,  1'b0);
        run_op("remu_zero",   3'b111, 32'h0000_1234,  32'd0,         5'd13, 32'h0000_1234, 2,  1'b0);
        run_op("div_zero_s",  3'b100, 32'hFFFF_FFF9,  32'd0,         5'd14, 32'hFFFF_FFFF, 2,  1'b0);
        run_op("rem_zero_s",  3'b110, 32'hFFFF_FFF9,  32'd0,         5'd15, 32'hFFFF_FFF9, 2,  1'b0);
        run_op("div_ovf",     3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 2,  1'b0);
        run_op("rem_ovf",     3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd17, 32'd0,         2,  1'b0);
        run_op("start_held",  3'b000, 32'd6,          32'd7,         5'd9,  32'd42,        33, 1'b1);
        run_op("rd_zero",     3'b101, 32'd100,        32'd7,         5'd0,  32'd14,        33, 1'b0);

        // Abort mid-CALC with an asynchronous reset
        start = 1'b1; funct3 = 3'b000; rs1_data = 32'd3; rs2_data = 32'd5; rd_in = 5'd20;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort busy",   busy,      1'b0);
        chk("abort done",   done,      1'b0);
        chk("abort result", result,    32'd0);
        chk("abort rd_out", rd_out,    5'd0);
        chk("abort wr",     write_reg, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort no_done", seen, 0);

        // Start presented together with reset release is accepted on the first edge
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_op("after_rst",   3'b000, 32'd3,          32'd5,         5'd21, 32'd15,        33, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
